// File: rtl/rv_mc_core_if.sv
// Fetch and load/store bus between rv_mc_core (master) and its memory (slave).
// Both ports are request/waitrequest: a request is accepted in a cycle
// where waitrequest is low, and read data is valid the cycle after acceptance.
interface rv_mc_core_if;
  logic [31:0] o_pc_addr;
  logic        o_pc_rd;
  logic [3:0]  o_pc_byte_en;
  logic        i_pc_waitrequest;
  logic [31:0] i_pc_rddata;

  logic [31:0] o_ldst_addr;
  logic        o_ldst_rd;
  logic        o_ldst_wr;
  logic        i_ldst_waitrequest;
  logic [31:0] i_ldst_rddata;
  logic [31:0] o_ldst_wrdata;
  logic [3:0]  o_ldst_byte_en;

  modport master (
    output o_pc_addr, o_pc_rd, o_pc_byte_en,
    input  i_pc_waitrequest, i_pc_rddata,
    output o_ldst_addr, o_ldst_rd, o_ldst_wr, o_ldst_wrdata, o_ldst_byte_en,
    input  i_ldst_waitrequest, i_ldst_rddata
  );

  modport slave (
    input  o_pc_addr, o_pc_rd, o_pc_byte_en,
    output i_pc_waitrequest, i_pc_rddata,
    input  o_ldst_addr, o_ldst_rd, o_ldst_wr, o_ldst_wrdata, o_ldst_byte_en,
    output i_ldst_waitrequest, i_ldst_rddata
  );
endinterface

// File: rtl/rv_mc_core.sv
// rv_mc_core: unpipelined multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/LWB).
// Any illegal or misaligned condition parks the core in HALT until reset.
// Optional feature: define RV_CORE_MUL_EN to accept MUL (low 32 bits of
// rs1*rs2); without it that encoding is illegal and halts the core.
module rv_mc_core #(
  parameter int          REGS     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  rv_mc_core_if.master           bus,
  output logic                   o_retire,
  output logic                   o_halt,
  output logic [REGS-1:0][31:0]  o_tb_regs
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_LWB    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [5:0] REGS_L = 6'(REGS);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        load_q, load_d;

  logic [31:0] regs_q [REGS];

  // Instruction fields always come from the latched instruction register.
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Register reads in DECODE index straight off the fetched word; x0 and
  // out-of-range indices read as zero (the latter halts in EXEC anyway).
  logic [4:0]  dec_rs1, dec_rs2;
  logic [31:0] rs1_rd, rs2_rd;
  assign dec_rs1 = bus.i_pc_rddata[19:15];
  assign dec_rs2 = bus.i_pc_rddata[24:20];

  // Register file read ports.
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    for (int i = 1; i < REGS; i++) begin
      if (dec_rs1 == 5'(i)) rs1_rd = regs_q[i];
      if (dec_rs2 == 5'(i)) rs2_rd = regs_q[i];
    end
  end

  // EXEC: decode, ALU, branch resolution, address generation, legality.
  logic        ex_illegal, ex_mem, ex_load, ex_wr_rd, taken;
  logic        use_rd, use_rs1, use_rs2;
  logic [31:0] ex_result, ex_next_pc, ex_addr, ex_wdata;
  logic [3:0]  ex_be;

  always_comb begin
    ex_illegal = 1'b0;
    ex_mem     = 1'b0;
    ex_load    = 1'b0;
    ex_wr_rd   = 1'b0;
    taken      = 1'b0;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    ex_result  = '0;
    ex_next_pc = pc_q + 32'd4;
    ex_addr    = '0;
    ex_wdata   = '0;
    ex_be      = '0;
    case (opcode)
      OP_LUI: begin
        use_rd = 1'b1; ex_wr_rd = 1'b1; ex_result = imm_u;
      end
      OP_AUIPC: begin
        use_rd = 1'b1; ex_wr_rd = 1'b1; ex_result = pc_q + imm_u;
      end
      OP_JAL: begin
        use_rd = 1'b1; ex_wr_rd = 1'b1; ex_result = pc_q + 32'd4;
        ex_next_pc = pc_q + imm_j;
        if (ex_next_pc[1:0] != 2'b00) ex_illegal = 1'b1;
      end
      OP_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_wr_rd = 1'b1; ex_result = pc_q + 32'd4;
        ex_next_pc = (rs1_q + imm_i) & ~32'd1;
        if (f3 != 3'b000 || ex_next_pc[1]) ex_illegal = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  taken = (rs1_q == rs2_q);
          3'b001:  taken = (rs1_q != rs2_q);
          3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
          3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
          3'b110:  taken = (rs1_q <  rs2_q);
          3'b111:  taken = (rs1_q >= rs2_q);
          default: ex_illegal = 1'b1;
        endcase
        if (taken) begin
          ex_next_pc = pc_q + imm_b;
          if (ex_next_pc[1:0] != 2'b00) ex_illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_mem = 1'b1; ex_load = 1'b1;
        ex_addr = rs1_q + imm_i;
        case (f3)
          3'b000, 3'b100: ex_be = 4'b0001 << ex_addr[1:0];
          3'b001, 3'b101: begin
            ex_be = 4'b0011 << ex_addr[1:0];
            if (ex_addr[0]) ex_illegal = 1'b1;
          end
          3'b010: begin
            ex_be = 4'b1111;
            if (ex_addr[1:0] != 2'b00) ex_illegal = 1'b1;
          end
          default: ex_illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; ex_mem = 1'b1;
        ex_addr = rs1_q + imm_s;
        case (f3)
          3'b000: begin
            ex_be = 4'b0001 << ex_addr[1:0];
            ex_wdata = {4{rs2_q[7:0]}};
          end
          3'b001: begin
            ex_be = 4'b0011 << ex_addr[1:0];
            ex_wdata = {2{rs2_q[15:0]}};
            if (ex_addr[0]) ex_illegal = 1'b1;
          end
          3'b010: begin
            ex_be = 4'b1111;
            ex_wdata = rs2_q;
            if (ex_addr[1:0] != 2'b00) ex_illegal = 1'b1;
          end
          default: ex_illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_wr_rd = 1'b1;
        case (f3)
          3'b000: ex_result = rs1_q + imm_i;
          3'b010: ex_result = {31'b0, $signed(rs1_q) < $signed(imm_i)};
          3'b011: ex_result = {31'b0, rs1_q < imm_i};
          3'b100: ex_result = rs1_q ^ imm_i;
          3'b110: ex_result = rs1_q | imm_i;
          3'b111: ex_result = rs1_q & imm_i;
          3'b001: begin
            ex_result = rs1_q << rs2;
            if (f7 != 7'b0000000) ex_illegal = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      ex_result = rs1_q >> rs2;
            else if (f7 == 7'b0100000) ex_result = $signed(rs1_q) >>> rs2;
            else                       ex_illegal = 1'b1;
          end
        endcase
      end
      OP_REG: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; ex_wr_rd = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  ex_result = rs1_q + rs2_q;
              3'b001:  ex_result = rs1_q << rs2_q[4:0];
              3'b010:  ex_result = {31'b0, $signed(rs1_q) < $signed(rs2_q)};
              3'b011:  ex_result = {31'b0, rs1_q < rs2_q};
              3'b100:  ex_result = rs1_q ^ rs2_q;
              3'b101:  ex_result = rs1_q >> rs2_q[4:0];
              3'b110:  ex_result = rs1_q | rs2_q;
              default: ex_result = rs1_q & rs2_q;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      ex_result = rs1_q - rs2_q;
            else if (f3 == 3'b101) ex_result = $signed(rs1_q) >>> rs2_q[4:0];
            else                   ex_illegal = 1'b1;
          end
`ifdef RV_CORE_MUL_EN
          7'b0000001: begin
            if (f3 == 3'b000) ex_result = rs1_q * rs2_q;
            else              ex_illegal = 1'b1;
          end
`endif
          default: ex_illegal = 1'b1;
        endcase
      end
      default: ex_illegal = 1'b1;
    endcase
    // An RV32E core must reject any reference to x16..x31.
    if ((use_rd  && {1'b0, rd}  >= REGS_L) ||
        (use_rs1 && {1'b0, rs1} >= REGS_L) ||
        (use_rs2 && {1'b0, rs2} >= REGS_L))
      ex_illegal = 1'b1;
  end

  // LWB: align the addressed lane down to bit 0, then extend by width/sign.
  logic [31:0] ld_shift, ld_data;
  always_comb begin
    ld_shift = bus.i_ldst_rddata >> {addr_q[1:0], 3'b000};
    case (f3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'b0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // Next-state logic for the control FSM and its datapath registers.
  logic        rf_we, retire;
  logic [31:0] rf_wdata;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    load_d   = load_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: if (!bus.i_pc_waitrequest) state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = bus.i_pc_rddata;
        rs1_d   = rs1_rd;
        rs2_d   = rs2_rd;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ex_illegal) begin
          state_d = S_HALT;
        end else if (ex_mem) begin
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          be_d    = ex_be;
          load_d  = ex_load;
          state_d = S_MEM;
        end else begin
          rf_we    = ex_wr_rd;
          rf_wdata = ex_result;
          pc_d     = ex_next_pc;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEM: begin
        if (!bus.i_ldst_waitrequest) begin
          if (load_q) begin
            state_d = S_LWB;
          end else begin
            retire  = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end
        end
      end
      S_LWB: begin
        rf_we    = 1'b1;
        rf_wdata = ld_data;
        retire   = 1'b1;
        pc_d     = pc_q + 32'd4;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Control and datapath registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      load_q  <= load_d;
    end
  end

  // Register file; x0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      for (int i = 1; i < REGS; i++)
        if (rd == 5'(i)) regs_q[i] <= rf_wdata;
    end
  end

  for (genvar gi = 0; gi < REGS; gi++) begin : g_tb_regs
    assign o_tb_regs[gi] = reset ? 32'h0 : regs_q[gi];
  end

  // Outputs are forced quiet while reset is held; requests only in FETCH/MEM.
  logic fetch_act, mem_act;
  assign fetch_act = !reset && (state_q == S_FETCH);
  assign mem_act   = !reset && (state_q == S_MEM);

  assign bus.o_pc_addr      = reset ? RESET_PC : pc_q;
  assign bus.o_pc_rd        = fetch_act;
  assign bus.o_pc_byte_en   = {4{fetch_act}};
  assign bus.o_ldst_addr    = mem_act ? addr_q : 32'h0;
  assign bus.o_ldst_rd      = mem_act && load_q;
  assign bus.o_ldst_wr      = mem_act && !load_q;
  assign bus.o_ldst_wrdata  = (mem_act && !load_q) ? wdata_q : 32'h0;
  assign bus.o_ldst_byte_en = mem_act ? be_q : 4'b0000;
  assign o_retire           = retire && !reset;
  assign o_halt             = !reset && (state_q == S_HALT);

endmodule

// File: tb/tb_rv_mc_core.sv
// Directed bench for rv_mc_core: a REGS=32 core runs two programs from a
// small memory model, a REGS=16 core runs an RV32E index-range program.
module tb_rv_mc_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rv_mc_core_if bus_a ();
  rv_mc_core_if bus_b ();
  logic                 ret_a, halt_a, ret_b, halt_b;
  logic [31:0][31:0]    regs_a;
  logic [15:0][31:0]    regs_b;

  rv_mc_core #(.REGS(32), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .o_retire(ret_a), .o_halt(halt_a), .o_tb_regs(regs_a));

  rv_mc_core #(.REGS(16), .RESET_PC(32'h0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .o_retire(ret_b), .o_halt(halt_b), .o_tb_regs(regs_b));

  logic [31:0] imem [64];
  logic [31:0] dmem [256];

  // Memory model for core A: read data the cycle after acceptance.
  always @(posedge clk) begin
    if (bus_a.o_pc_rd && !bus_a.i_pc_waitrequest)
      bus_a.i_pc_rddata <= imem[bus_a.o_pc_addr[7:2]];
    if (bus_a.o_ldst_rd && !bus_a.i_ldst_waitrequest)
      bus_a.i_ldst_rddata <= dmem[bus_a.o_ldst_addr[9:2]];
    if (bus_a.o_ldst_wr && !bus_a.i_ldst_waitrequest)
      for (int l = 0; l < 4; l++)
        if (bus_a.o_ldst_byte_en[l])
          dmem[bus_a.o_ldst_addr[9:2]][8*l +: 8] <= bus_a.o_ldst_wrdata[8*l +: 8];
  end

  // Fixed program for core B: ADDI x0,x0,7 ; ADDI x1,x0,3 ; ADD x17,x1,x2.
  always @(posedge clk) begin
    if (bus_b.o_pc_rd && !bus_b.i_pc_waitrequest)
      case (bus_b.o_pc_addr)
        32'h0:   bus_b.i_pc_rddata <= 32'h00700013;
        32'h4:   bus_b.i_pc_rddata <= 32'h00300093;
        32'h8:   bus_b.i_pc_rddata <= 32'h002088B3;
        default: bus_b.i_pc_rddata <= 32'h00000000;
      endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  int          n_ret;
  int          ret_cyc [16];
  logic        stall_en, saw_ldst_rd;
  int          fstall, lstall;
  logic [31:0] snap_x1, snap_x2, sw_data;
  logic [3:0]  sw_be;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_pc_rd",   {31'b0, bus_a.o_pc_rd},  32'h0);
    check("rst_pc_addr", bus_a.o_pc_addr,         32'h0);
    check("rst_halt",    {31'b0, halt_a},         32'h0);
    check("rst_retire",  {31'b0, ret_a},          32'h0);
    check("rst_ldst",    {30'b0, bus_a.o_ldst_rd, bus_a.o_ldst_wr}, 32'h0);
    check("rst_x1",      regs_a[1],               32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_pc_rd",   {31'b0, bus_a.o_pc_rd},   32'h1);
    check("first_pc_be",   {28'b0, bus_a.o_pc_byte_en}, 32'hF);
    check("first_pc_addr", bus_a.o_pc_addr,          32'h0);
  endtask

  task automatic run_prog(input int max_cyc);
    int cyc;
    cyc = 0;
    n_ret = 0;
    fstall = 0;
    lstall = 0;
    saw_ldst_rd = 1'b0;
    while (!halt_a && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      bus_a.i_pc_waitrequest   = 1'b0;
      bus_a.i_ldst_waitrequest = 1'b0;
      if (stall_en && n_ret == 7 && bus_a.o_ldst_rd && lstall < 4) begin
        lstall++;
        bus_a.i_ldst_waitrequest = 1'b1;
        check("lw_hold_addr", bus_a.o_ldst_addr, 32'h100);
        check("lw_hold_be",   {28'b0, bus_a.o_ldst_byte_en}, 32'hF);
      end
      if (stall_en && n_ret == 8 && bus_a.o_pc_rd && fstall < 2) begin
        fstall++;
        bus_a.i_pc_waitrequest = 1'b1;
        check("fetch_hold_addr", bus_a.o_pc_addr, 32'h20);
      end
      if (bus_a.o_ldst_rd) saw_ldst_rd = 1'b1;
      if (bus_a.o_ldst_wr) begin
        sw_be   = bus_a.o_ldst_byte_en;
        sw_data = bus_a.o_ldst_wrdata;
      end
      if (ret_a) begin
        if (n_ret == 2) begin
          snap_x1 = regs_a[1];
          snap_x2 = regs_a[2];
        end
        if (n_ret < 16) ret_cyc[n_ret] = cyc;
        n_ret++;
      end
    end
    check("halt_reached", {31'b0, halt_a}, 32'h1);
  endtask

  initial begin
    bus_a.i_pc_waitrequest   = 1'b0;
    bus_a.i_ldst_waitrequest = 1'b0;
    bus_b.i_pc_waitrequest   = 1'b0;
    bus_b.i_ldst_waitrequest = 1'b0;
    bus_b.i_ldst_rddata      = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;

    // Program 1: ALU, byte loads/stores, stalled LW and fetch, branch, jump, MUL.
    imem[0]  = 32'hFFB00093; // ADDI  x1,x0,-5
    imem[1]  = 32'h0010B113; // SLTIU x2,x1,1
    imem[2]  = 32'h112230B7; // LUI   x1,0x11223
    imem[3]  = 32'h34408093; // ADDI  x1,x1,0x344
    imem[4]  = 32'h10102023; // SW    x1,0x100(x0)
    imem[5]  = 32'h10100183; // LB    x3,0x101(x0)
    imem[6]  = 32'h10304203; // LBU   x4,0x103(x0)
    imem[7]  = 32'h10002283; // LW    x5,0x100(x0)
    imem[8]  = 32'h00700393; // ADDI  x7,x0,7
    imem[9]  = 32'hFFD00413; // ADDI  x8,x0,-3
    imem[10] = 32'h0083E463; // BLTU  x7,x8,+8
    imem[11] = 32'h00100513; // ADDI  x10,x0,1 (skipped)
    imem[12] = 32'h008005EF; // JAL   x11,+8
    imem[13] = 32'h00100513; // ADDI  x10,x0,1 (skipped)
    imem[14] = 32'h028384B3; // MUL   x9,x7,x8
    imem[15] = 32'h00000000; // illegal
    stall_en = 1'b1;
    do_reset();
    run_prog(600);

    check("addi_x1",   snap_x1, 32'hFFFFFFFB);
    check("sltiu_x2",  snap_x2, 32'h0);
    check("alu_gap",   32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
    check("sw_gap",    32'(ret_cyc[4] - ret_cyc[3]), 32'd4);
    check("lb_gap",    32'(ret_cyc[5] - ret_cyc[4]), 32'd5);
    check("lw_gap",    32'(ret_cyc[7] - ret_cyc[6]), 32'd9);
    check("fstall_gap", 32'(ret_cyc[8] - ret_cyc[7]), 32'd5);
    check("sw_be",     {28'b0, sw_be}, 32'hF);
    check("sw_wrdata", sw_data, 32'h11223344);
    check("dmem_word", dmem[64], 32'h11223344);
    check("lb_x3",     regs_a[3], 32'h00000033);
    check("lbu_x4",    regs_a[4], 32'h00000011);
    check("lw_x5",     regs_a[5], 32'h11223344);
    check("skip_x10",  regs_a[10], 32'h0);
    check("jal_x11",   regs_a[11], 32'h34);
`ifdef RV_CORE_MUL_EN
    check("retires",   32'(n_ret), 32'd13);
    check("mul_x9",    regs_a[9], 32'hFFFFFFEB);
    check("halt_pc",   bus_a.o_pc_addr, 32'h3C);
`else
    check("retires",   32'(n_ret), 32'd12);
    check("mul_x9",    regs_a[9], 32'h0);
    check("halt_pc",   bus_a.o_pc_addr, 32'h38);
`endif
    repeat (3) @(negedge clk);
    check("halt_stays",  {31'b0, halt_a}, 32'h1);
    check("halt_no_req", {29'b0, bus_a.o_pc_rd, bus_a.o_ldst_rd, bus_a.o_ldst_wr}, 32'h0);

    // Core B (RV32E) ran alongside from the same reset.
    check("b_halt",    {31'b0, halt_b}, 32'h1);
    check("b_x0",      regs_b[0], 32'h0);
    check("b_x1",      regs_b[1], 32'h3);
    check("b_halt_pc", bus_b.o_pc_addr, 32'h8);

    // Program 2: misaligned halfword load halts with no side effects.
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0] = 32'h10000093;  // ADDI x1,x0,0x100
    imem[1] = 32'h00109303;  // LH   x6,1(x1)
    stall_en = 1'b0;
    do_reset();
    run_prog(200);
    check("lh_retires", 32'(n_ret), 32'd1);
    check("lh_x1",      regs_a[1], 32'h100);
    check("lh_x6",      regs_a[6], 32'h0);
    check("lh_no_rd",   {31'b0, saw_ldst_rd}, 32'h0);
    check("lh_halt_pc", bus_a.o_pc_addr, 32'h4);

    // Reset out of HALT fetches from RESET_PC again.
    do_reset();
    check("post_rst_halt", {31'b0, halt_a}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
